// File: rtl/cfg_reg_responder.sv
// Tile configuration/identity register responder on the OCL host register path.
// Optional ERR_CNT register at 0x1C is built when CFG_ERR_CNT_EN is defined.
package swarm;
    localparam logic [31:0] VERSION           = 32'h0003_0201;
    localparam int          N_TILES           = 4;
    localparam int          N_THREADS         = 16;
    localparam int          LOG_TQ_SIZE       = 10;
    localparam int          LOG_CQ_SLICE_SIZE = 6;
    localparam bit          CQ_CONFIG         = 1'b1;
    localparam bit          NO_SPILLING       = 1'b0;
endpackage

module cfg_reg_responder
    import swarm::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int CQ_MAX    = 1 << swarm::LOG_CQ_SLICE_SIZE,
    parameter bit CQ_CFG    = swarm::CQ_CONFIG,
    parameter bit SPILL_RST = !swarm::NO_SPILLING
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [ADDR_W-1:0]              awaddr,
    input  logic                           wvalid,
    output logic                           wready,
    input  logic [DATA_W-1:0]              wdata,
    output logic                           bvalid,
    input  logic                           bready,
    output logic [1:0]                     bresp,
    input  logic                           arvalid,
    output logic                           arready,
    input  logic [ADDR_W-1:0]              araddr,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [DATA_W-1:0]              rdata,
    output logic [1:0]                     rresp,
    output logic [LOG_CQ_SLICE_SIZE:0]     cfg_cq_size,
    output logic                           cfg_spill_en,
    output logic                           cfg_update
);

    localparam int CQW = LOG_CQ_SLICE_SIZE + 1;
    localparam int IW  = ADDR_W - 2;

    localparam logic [IW-1:0] A_VER  = IW'(0);
    localparam logic [IW-1:0] A_NT   = IW'(1);
    localparam logic [IW-1:0] A_NTH  = IW'(2);
    localparam logic [IW-1:0] A_LOG  = IW'(3);
    localparam logic [IW-1:0] A_CQ   = IW'(4);
    localparam logic [IW-1:0] A_SCR  = IW'(5);
    localparam logic [IW-1:0] A_CTRL = IW'(6);
`ifdef CFG_ERR_CNT_EN
    localparam logic [IW-1:0] A_ERR  = IW'(7);
`endif

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    typedef enum logic { W_IDLE, W_RESP } wstate_e;
    typedef enum logic { R_IDLE, R_RESP } rstate_e;

    wstate_e             wstate_q, wstate_d;
    rstate_e             rstate_q, rstate_d;
    logic                aw_held_q, aw_held_d;
    logic                w_held_q, w_held_d;
    logic [IW-1:0]       awidx_q, awidx_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          bresp_q, bresp_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [CQW-1:0]      cq_q, cq_d;
    logic [DATA_W-1:0]   scratch_q, scratch_d;
    logic                spill_q, spill_d;
    logic                upd_q, upd_d;

    logic                aw_fire, w_fire, ar_fire, commit;
    logic [IW-1:0]       wr_idx, ar_idx;
    logic [DATA_W-1:0]   wr_data, rd_val;
    logic                wr_map, rd_map;
    logic [CQW-1:0]      cq_new;
    logic                unused_addr_lsb;

    assign unused_addr_lsb = ^{awaddr[1:0], araddr[1:0]};

    assign awready = (wstate_q == W_IDLE) && !aw_held_q;
    assign wready  = (wstate_q == W_IDLE) && !w_held_q;
    assign bvalid  = (wstate_q == W_RESP);
    assign bresp   = bresp_q;
    assign arready = (rstate_q == R_IDLE);
    assign rvalid  = (rstate_q == R_RESP);
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

    assign cfg_cq_size  = cq_q;
    assign cfg_spill_en = spill_q;
    assign cfg_update   = upd_q;

    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;
    assign ar_fire = arvalid && arready;
    assign wr_idx  = aw_held_q ? awidx_q : awaddr[ADDR_W-1:2];
    assign wr_data = w_held_q ? wdata_q : wdata;
    assign ar_idx  = araddr[ADDR_W-1:2];
    assign commit  = (wstate_q == W_IDLE)
                   && (aw_held_q || aw_fire)
                   && (w_held_q || w_fire);

    // Host values outside [1, CQ_MAX] are clamped silently.
    always_comb begin
        cq_new = wr_data[CQW-1:0];
        if (wr_data == '0) begin
            cq_new = CQW'(1);
        end else if (wr_data > DATA_W'(CQ_MAX)) begin
            cq_new = CQW'(CQ_MAX);
        end
    end

`ifdef CFG_ERR_CNT_EN
    logic [15:0] err_q, err_d;
    logic        wr_err, rd_err, err_clr;
    logic [16:0] err_sum;

    assign wr_err  = commit && !wr_map;
    assign rd_err  = ar_fire && !rd_map;
    assign err_clr = commit && (wr_idx == A_ERR);
    assign err_sum = {1'b0, err_q} + 17'(wr_err) + 17'(rd_err);

    always_comb begin
        err_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        if (err_clr) begin
            err_d = '0;
        end
    end
`endif

    always_comb begin
        rd_map = 1'b1;
        rd_val = '0;
        case (ar_idx)
            A_VER:  rd_val = DATA_W'(VERSION);
            A_NT:   rd_val = DATA_W'(N_TILES);
            A_NTH:  rd_val = DATA_W'(N_THREADS);
            A_LOG:  rd_val = DATA_W'({16'b0, 8'(LOG_TQ_SIZE),
                                      8'(LOG_CQ_SLICE_SIZE)});
            A_CQ:   rd_val = DATA_W'(cq_q);
            A_SCR:  rd_val = scratch_q;
            A_CTRL: rd_val = DATA_W'(spill_q);
`ifdef CFG_ERR_CNT_EN
            A_ERR:  rd_val = DATA_W'(err_q);
`endif
            default: begin
                rd_map = 1'b0;
                rd_val = DATA_W'(32'hDEAD_BEEF);
            end
        endcase
    end

    always_comb begin
        wr_map = 1'b1;
        case (wr_idx)
            A_VER, A_NT, A_NTH, A_LOG, A_CQ, A_SCR, A_CTRL: wr_map = 1'b1;
`ifdef CFG_ERR_CNT_EN
            A_ERR:   wr_map = 1'b1;
`endif
            default: wr_map = 1'b0;
        endcase
    end

    always_comb begin
        wstate_d  = wstate_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awidx_d   = awidx_q;
        wdata_d   = wdata_q;
        bresp_d   = bresp_q;
        cq_d      = cq_q;
        scratch_d = scratch_q;
        spill_d   = spill_q;
        upd_d     = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (aw_fire) begin
                    aw_held_d = 1'b1;
                    awidx_d   = awaddr[ADDR_W-1:2];
                end
                if (w_fire) begin
                    w_held_d = 1'b1;
                    wdata_d  = wdata;
                end
                if (commit) begin
                    wstate_d = W_RESP;
                    bresp_d  = wr_map ? RESP_OKAY : RESP_SLVERR;
                    case (wr_idx)
                        A_CQ: begin
                            if (CQ_CFG) begin
                                cq_d  = cq_new;
                                upd_d = (cq_new != cq_q);
                            end
                        end
                        A_SCR: begin
                            scratch_d = wr_data;
                            upd_d     = (wr_data != scratch_q);
                        end
                        A_CTRL: begin
                            spill_d = wr_data[0];
                            upd_d   = (wr_data[0] != spill_q);
                        end
                        default: ;
                    endcase
                end
            end
            W_RESP: begin
                if (bready) begin
                    wstate_d  = W_IDLE;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        case (rstate_q)
            R_IDLE: begin
                if (arvalid) begin
                    rstate_d = R_RESP;
                    rdata_d  = rd_val;
                    rresp_d  = rd_map ? RESP_OKAY : RESP_SLVERR;
                end
            end
            R_RESP: begin
                if (rready) begin
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awidx_q   <= '0;
            wdata_q   <= '0;
            bresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            cq_q      <= CQW'(CQ_MAX);
            scratch_q <= '0;
            spill_q   <= SPILL_RST;
            upd_q     <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awidx_q   <= awidx_d;
            wdata_q   <= wdata_d;
            bresp_q   <= bresp_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            cq_q      <= cq_d;
            scratch_q <= scratch_d;
            spill_q   <= spill_d;
            upd_q     <= upd_d;
        end
    end

`ifdef CFG_ERR_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

endmodule
